// File: rtl/ysyx_22041461_mem_arbiter.sv
// ysyx_22041461_mem_arbiter
//   Shares one memory bus port between the instruction fetch (IF) and the
//   load/store (MEM) requesters. One bus transaction is in flight at a time.
//   MEM has priority, but a starvation counter forces an IF grant after
//   STARVE_MAX consecutive MEM grants made while IF was waiting.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   if_req_*/if_addr      fetch request handshake and address
//   if_resp_valid/rdata   one-cycle fetch response pulse, 32-bit instruction
//   if_flush              drop the outstanding fetch response
//   mem_req_*/mem_*       load/store request handshake and fields
//   mem_resp_valid/rdata  one-cycle load/store completion pulse, 64-bit data
//   bus_*                 shared downstream port (request + response)
module ysyx_22041461_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  // fetch side
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  input  logic        if_flush,
  // load/store side
  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        mem_resp_valid,
  output logic [63:0] mem_rdata,
  // shared bus
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [63:0] bus_addr,
  output logic        bus_wen,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  input  logic        bus_resp_valid,
  input  logic [63:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1) + 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]      r_state, w_state_nxt;
  logic [CntW-1:0] r_starve;
  logic            r_owner_if;  // 1: transaction in flight belongs to IF
  logic            r_drop;
  logic [63:0]     r_addr;
  logic            r_wen;
  logic [63:0]     r_wdata;
  logic [7:0]      r_wmask;
  logic            r_if_resp_valid;
  logic            r_mem_resp_valid;
  logic [31:0]     r_if_rdata;
  logic [63:0]     r_mem_rdata;

  logic w_idle;
  logic w_starved;
  logic w_if_win;
  logic w_mem_win;
  logic w_resp;

  assign w_idle    = (r_state == StIdle);
  assign w_starved = (r_starve >= CntW'(STARVE_MAX));
  // MEM wins unless IF has been passed over STARVE_MAX times in a row
  assign w_if_win  = w_idle && if_req_valid && (!mem_req_valid || w_starved);
  assign w_mem_win = w_idle && mem_req_valid && !w_if_win;
  // Responses are only meaningful while waiting; anything else is ignored
  assign w_resp    = (r_state == StWait) && bus_resp_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_if_win || w_mem_win) w_state_nxt = StReq;
      StReq:   if (bus_req_ready) w_state_nxt = StWait;
      StWait:  if (bus_resp_valid) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holding registers: the bus is driven from these only, so it stays stable
  // for the whole REQ phase regardless of what the requesters do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_if <= 1'b0;
      r_addr     <= '0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else if (w_if_win) begin
      r_owner_if <= 1'b1;
      r_addr     <= if_addr;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else if (w_mem_win) begin
      r_owner_if <= 1'b0;
      r_addr     <= mem_addr;
      r_wen      <= mem_wen;
      r_wdata    <= mem_wdata;
      r_wmask    <= mem_wmask;
    end
  end

  // Counts MEM grants that bypassed a waiting IF; never exceeds STARVE_MAX
  // because a saturated count hands the next contested grant to IF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_idle) begin
      if (w_if_win || !if_req_valid) begin
        r_starve <= '0;
      end else if (w_mem_win) begin
        r_starve <= r_starve + CntW'(1);
      end
    end
  end

  // Fetch drop flag: a flushed fetch still finishes on the bus but returns
  // nothing to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 1'b0;
    end else if (w_resp) begin
      r_drop <= 1'b0;
    end else if (!w_idle && r_owner_if && if_flush) begin
      r_drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_resp_valid  <= 1'b0;
      r_mem_resp_valid <= 1'b0;
      r_if_rdata       <= '0;
      r_mem_rdata      <= '0;
    end else begin
      // A flush arriving with the response itself also kills the pulse
      r_if_resp_valid  <= w_resp && r_owner_if && !r_drop && !if_flush;
      r_mem_resp_valid <= w_resp && !r_owner_if;
      if (w_resp && r_owner_if) begin
        r_if_rdata <= r_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];
      end
      if (w_resp && !r_owner_if) begin
        r_mem_rdata <= bus_rdata;
      end
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is applied
  assign if_req_ready   = w_if_win && !rst;
  assign mem_req_ready  = w_mem_win && !rst;
  // Flush in the pulse cycle suppresses the pulse combinationally
  assign if_resp_valid  = r_if_resp_valid && !if_flush;
  assign if_rdata       = r_if_rdata;
  assign mem_resp_valid = r_mem_resp_valid;
  assign mem_rdata      = r_mem_rdata;

  assign bus_req_valid  = (r_state == StReq);
  assign bus_addr       = r_addr;
  assign bus_wen        = r_wen;
  assign bus_wdata      = r_wdata;
  assign bus_wmask      = r_wmask;

endmodule

// File: doc/ysyx_22041461_mem_arbiter.md
YSYX_22041461_MEM_ARBITER -- requirements
Module: ysyx_22041461_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  - STARVE_MAX, 2, consecutive MEM grants allowed while IF is pending before IF is forced.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  - clk  in  1  single clock; all state updates on its rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - if_req_valid  in  1  fetch request.
  - if_req_ready  out  1  fetch request accepted.
  - if_addr  in  64  fetch address.
  - if_resp_valid  out  1  fetch data valid, one-cycle pulse.
  - if_rdata  out  32  fetch instruction.
  - if_flush  in  1  discard the outstanding fetch response.
  - mem_req_valid  in  1  load/store request.
  - mem_req_ready  out  1  load/store accepted.
  - mem_addr  in  64  load/store address.
  - mem_wen  in  1  1 = store.
  - mem_wdata  in  64  store data.
  - mem_wmask  in  8  byte enables.
  - mem_resp_valid  out  1  load data valid, or store done; one-cycle pulse.
  - mem_rdata  out  64  load data.
  - bus_req_valid  out  1  shared-port request.
  - bus_req_ready  in  1  shared-port accept.
  - bus_addr  out  64  shared-port address.
  - bus_wen  out  1  shared-port write enable.
  - bus_wdata  out  64  shared-port write data.
  - bus_wmask  out  8  shared-port byte enables.
  - bus_resp_valid  in  1  shared-port response.
  - bus_rdata  in  64  shared-port read data.
REQ-003 The clock and reset SHALL be exactly as stated: one clock, clk; reset rst, asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, REQ and WAIT, with at most one bus transaction outstanding.
REQ-005 In IDLE, arbitration SHALL select one winner combinationally and assert only that requester's req_ready; the accepted request's fields SHALL be latched into holding registers and the FSM SHALL go to REQ.
REQ-006 IF requests SHALL latch wen=0 and wmask=0; address, wen, wdata and wmask SHALL be driven onto bus_* from the holding registers only.
REQ-007 Priority SHALL be MEM over IF.
REQ-008 The starvation counter SHALL behave as follows:
  - It counts MEM grants made while if_req_valid=1.
  - When it equals STARVE_MAX and both requesters are valid, IF SHALL win.
  - It SHALL clear on any IF grant, and on any IDLE cycle with if_req_valid=0.
REQ-009 In REQ, bus_req_valid SHALL be 1 and the FSM SHALL stay in REQ until bus_req_ready=1, then go to WAIT; bus_* SHALL be held stable while waiting.
REQ-010 In WAIT, on bus_resp_valid=1 the FSM SHALL return to IDLE and, in the next cycle, pulse the owner's resp_valid for exactly one cycle with registered data.
REQ-011 Response data SHALL be formed as follows:
  - if_rdata = bus_rdata[63:32] when latched addr[2]=1, else bus_rdata[31:0].
  - mem_rdata = bus_rdata unmodified.
REQ-012 Minimum latency SHALL be 3 cycles from IDLE acceptance to resp_valid: accept, REQ with immediate ready, response in the first WAIT cycle, registered pulse.
REQ-013 IDLE MAY accept a new request in the same cycle a resp_valid pulse is driven.
REQ-014 Fetch flush SHALL be handled as follows:
  - if_flush=1 while an IF transaction is in REQ or WAIT SHALL set a drop flag; the transaction SHALL still complete on the bus, and if_resp_valid SHALL be suppressed.
  - A flush in the same cycle as the pulse SHALL suppress that pulse.
  - A flush has no effect on MEM transactions.
  - The drop flag SHALL clear on return to IDLE.
REQ-015 bus_resp_valid received outside WAIT SHALL be ignored.
REQ-016 If both requesters drop valid before being granted, no state change SHALL occur.

Reset
REQ-017 On rst=1, the block SHALL asynchronously apply the following, regardless of any in-flight transaction, which is abandoned:
  - FSM = IDLE.
  - Starvation counter = 0 and drop flag = 0.
  - All resp_valid, req_ready and bus_req_valid = 0.
  - bus_addr, bus_wdata, bus_wmask, bus_wen and all rdata outputs = 0.
REQ-018 After rst deasserts, the first request SHALL be acceptable in the first IDLE cycle.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
  - IF-only read: if_addr=0x80000004, bus_rdata=0x11223344_55667788, immediate ready and response -> if_rdata=0x11223344, one if_resp_valid pulse, 3-cycle latency.
  - Simultaneous requests: IF and MEM valid -> MEM granted first.
  - Starvation: with STARVE_MAX=2 and both valid continuously -> grant order MEM, MEM, IF, MEM, MEM, IF.
  - Store: mem_wen=1, wdata=0xDEADBEEF_0BADF00D, wmask=0x0F, bus_req_ready held low 4 cycles -> bus_* stable all 4 cycles; mem_resp_valid pulses once after the response.
  - Flush: if_flush during IF WAIT -> bus completes, no if_resp_valid; the next MEM request is accepted in the following IDLE.
  - Reset mid-WAIT: rst asserted -> outputs 0 within the same cycle; a late bus_resp_valid is ignored; no resp pulse.
